// File: rtl/ttt_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ttt_defs (package)
//  Purpose  : Shared tic-tac-toe constants: cell codes, outcome codes, square
//             codes and the referee state type. The turn FSM uses the same
//             constants.
//  Revision : 1.0  initial release
// ============================================================================
package ttt_defs;

    // Cell codes; the player codes double as the "user" value of the mover.
    localparam logic [1:0] EMPTY_CELL  = 2'b00;
    localparam logic [1:0] P1_CELL     = 2'b01;
    localparam logic [1:0] P2_CELL     = 2'b10;

    // Game outcome codes (4..7 are never produced).
    localparam logic [2:0] IN_PROGRESS = 3'd0;
    localparam logic [2:0] P1_WIN      = 3'd1;
    localparam logic [2:0] P1_LOSE     = 3'd2;
    localparam logic [2:0] TIE         = 3'd3;

    // Square codes as carried on the move bus.
    localparam logic [3:0] SQ_A1 = 4'd1;
    localparam logic [3:0] SQ_A2 = 4'd2;
    localparam logic [3:0] SQ_A3 = 4'd3;
    localparam logic [3:0] SQ_B1 = 4'd4;
    localparam logic [3:0] SQ_B2 = 4'd5;
    localparam logic [3:0] SQ_B3 = 4'd6;
    localparam logic [3:0] SQ_C1 = 4'd7;
    localparam logic [3:0] SQ_C2 = 4'd8;
    localparam logic [3:0] SQ_C3 = 4'd9;

    localparam logic [3:0] MAX_MOVES = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_OVER = 2'd2
    } judge_state_t;

endpackage : ttt_defs
`default_nettype wire

// File: rtl/move_judge_line_checker.sv
`default_nettype none
// ============================================================================
//  Module   : line_checker
//  Purpose  : Combinational three-in-a-row detector for one player.
//  Ports    : board  [17:0] packed board, cell k at bits [2k-1:2k-2]
//             player [1:0]  cell code to look for (P1_CELL or P2_CELL)
//             win           high when any row, column or diagonal is all player
//  Revision : 1.0  initial release
// ============================================================================
module line_checker
    import ttt_defs::*;
(
    input  logic [17:0] board,
    input  logic [1:0]  player,
    output logic        win
);

    // w_own[i] marks square i (0-based, A1..C3) as owned by player.
    logic [8:0] w_own;

    for (genvar i = 0; i < 9; i++) begin : g_cell
        assign w_own[i] = (board[2*i +: 2] == player);
    end

    assign win = (w_own[0] & w_own[1] & w_own[2]) |   // row A
                 (w_own[3] & w_own[4] & w_own[5]) |   // row B
                 (w_own[6] & w_own[7] & w_own[8]) |   // row C
                 (w_own[0] & w_own[3] & w_own[6]) |   // column 1
                 (w_own[1] & w_own[4] & w_own[7]) |   // column 2
                 (w_own[2] & w_own[5] & w_own[8]) |   // column 3
                 (w_own[0] & w_own[4] & w_own[8]) |   // diagonal A1-C3
                 (w_own[2] & w_own[4] & w_own[6]);    // diagonal A3-C1

endmodule : line_checker
`default_nettype wire

// File: rtl/move_judge.sv
`default_nettype none
// ============================================================================
//  Module   : move_judge
//  Purpose  : Referee stage. Owns the 3x3 board, commits a move on the rising
//             edge of check, pulses valid or reject, then evaluates the board
//             one cycle later and registers the game outcome.
//  Ports    : clk, rst (sync, active-low), new_game (sync clear)
//             move[3:0] square 1..9, check (raw button level), user[1:0] mover
//             valid / reject  one-cycle pulses
//             outcome[2:0]    0 in progress, 1 P1 win, 2 P1 lose, 3 tie
//             board[17:0]     packed cells, move_count[3:0] committed moves
//  Revision : 1.0  initial release
// ============================================================================
module move_judge
    import ttt_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic [3:0]  move,
    input  logic        check,
    input  logic [1:0]  user,
    output logic        valid,
    output logic        reject,
    output logic [2:0]  outcome,
    output logic [17:0] board,
    output logic [3:0]  move_count
);

    judge_state_t r_state;
    logic         r_check_d;
    logic         r_valid;
    logic         r_reject;
    logic [2:0]   r_outcome;
    logic [17:0]  r_board;
    logic [3:0]   r_move_count;

    logic         w_chk_rise;
    logic [1:0]   w_cell;
    logic         w_legal;
    logic         w_p1_win;
    logic         w_p2_win;
    logic [2:0]   w_eval_outcome;

    assign w_chk_rise = check & ~r_check_d;

    // Contents of the addressed square; illegal codes read as occupied-free
    // but are rejected by the range test below.
    always_comb begin
        w_cell = EMPTY_CELL;
        for (int k = 1; k <= 9; k++) begin
            if (move == 4'(k)) begin
                w_cell = r_board[2*k-2 +: 2];
            end
        end
    end

    assign w_legal = (move >= SQ_A1) && (move <= SQ_C3) &&
                     (w_cell == EMPTY_CELL) &&
                     ((user == P1_CELL) || (user == P2_CELL));

    line_checker u_p1_lines (
        .board  (r_board),
        .player (P1_CELL),
        .win    (w_p1_win)
    );

    line_checker u_p2_lines (
        .board  (r_board),
        .player (P2_CELL),
        .win    (w_p2_win)
    );

    // P1 lines take precedence; a full board with no line is a tie.
    always_comb begin
        w_eval_outcome = IN_PROGRESS;
        if (w_p1_win) begin
            w_eval_outcome = P1_WIN;
        end else if (w_p2_win) begin
            w_eval_outcome = P1_LOSE;
        end else if (r_move_count == MAX_MOVES) begin
            w_eval_outcome = TIE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || new_game) begin
            // check_d starts high so a button held through the clear is not
            // mistaken for a fresh press.
            r_state      <= ST_IDLE;
            r_check_d    <= 1'b1;
            r_valid      <= 1'b0;
            r_reject     <= 1'b0;
            r_outcome    <= IN_PROGRESS;
            r_board      <= '0;
            r_move_count <= '0;
        end else begin
            r_check_d <= check;
            r_valid   <= 1'b0;
            r_reject  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_chk_rise) begin
                        if (w_legal) begin
                            for (int k = 1; k <= 9; k++) begin
                                if (move == 4'(k)) begin
                                    r_board[2*k-2 +: 2] <= user;
                                end
                            end
                            if (r_move_count != MAX_MOVES) begin
                                r_move_count <= r_move_count + 4'd1;
                            end
                            r_valid <= 1'b1;
                            r_state <= ST_EVAL;
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end
                end
                ST_EVAL: begin
                    r_outcome <= w_eval_outcome;
                    r_state   <= (w_eval_outcome != IN_PROGRESS) ? ST_OVER : ST_IDLE;
                end
                ST_OVER: begin
                    r_state <= ST_OVER;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign valid      = r_valid;
    assign reject     = r_reject;
    assign outcome    = r_outcome;
    assign board      = r_board;
    assign move_count = r_move_count;

endmodule : move_judge
`default_nettype wire

// File: tb/tb_move_judge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_move_judge
//  Purpose  : Self-checking bench for move_judge with a game-level reference
//             model (cell array, line table, move count).
//  Revision : 1.0  initial release
// ============================================================================
module tb_move_judge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        new_game = 1'b0;
    logic [3:0]  move = 4'd0;
    logic        check = 1'b0;
    logic [1:0]  user = 2'd0;
    logic        valid;
    logic        reject;
    logic [2:0]  outcome;
    logic [17:0] board;
    logic [3:0]  move_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: owner of each square 1..9, moves, outcome, game over.
    int       m_cells[10];
    int       m_count;
    logic [2:0] m_outcome;
    bit       m_over;

    int lines[8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                        '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

    move_judge dut (
        .clk        (clk),
        .rst        (rst),
        .new_game   (new_game),
        .move       (move),
        .check      (check),
        .user       (user),
        .valid      (valid),
        .reject     (reject),
        .outcome    (outcome),
        .board      (board),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        for (int i = 0; i < 10; i++) m_cells[i] = 0;
        m_count   = 0;
        m_outcome = 3'd0;
        m_over    = 1'b0;
    endfunction

    function automatic bit has_line(input int p);
        for (int l = 0; l < 8; l++)
            if (m_cells[lines[l][0]] == p && m_cells[lines[l][1]] == p &&
                m_cells[lines[l][2]] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] model_judge();
        if (has_line(1)) return 3'd1;
        if (has_line(2)) return 3'd2;
        if (m_count == 9) return 3'd3;
        return 3'd0;
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] b;
        b = '0;
        for (int k = 1; k <= 9; k++) b[2*k-2 +: 2] = 2'(m_cells[k]);
        return b;
    endfunction

    task automatic do_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
    endtask

    // One complete press: rise, sample pulse, sample outcome, release.
    task automatic press(input logic [3:0] mv, input logic [1:0] us, input string tag);
        logic exp_v;
        logic exp_r;
        exp_v = 1'b0;
        exp_r = 1'b0;
        if (!m_over) begin
            if (mv >= 1 && mv <= 9 && (us == 2'd1 || us == 2'd2) && m_cells[mv] == 0) begin
                exp_v = 1'b1;
                m_cells[mv] = int'(us);
                m_count++;
            end else begin
                exp_r = 1'b1;
            end
        end
        @(negedge clk);
        move = mv; user = us; check = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (valid !== exp_v || reject !== exp_r) begin
            miscompares++;
            $display("FAIL %s pulse: valid/reject got %b%b expected %b%b", tag, valid, reject, exp_v, exp_r);
        end
        vectors++;
        if (board !== model_board() || move_count !== 4'(m_count)) begin
            miscompares++;
            $display("FAIL %s state: board/count got %h/%0d expected %h/%0d", tag, board, move_count, model_board(), m_count);
        end
        @(posedge clk); #1;
        if (exp_v) begin
            m_outcome = model_judge();
            m_over    = (m_outcome != 3'd0);
        end
        vectors++;
        if (valid !== 1'b0 || reject !== 1'b0 || outcome !== m_outcome) begin
            miscompares++;
            $display("FAIL %s outcome: valid/reject/outcome got %b%b/%0d expected 00/%0d", tag, valid, reject, outcome, m_outcome);
        end
        @(negedge clk);
        check = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; check = 1'b1; move = 4'd5; user = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (board !== 18'd0 || outcome !== 3'd0 || move_count !== 4'd0 || valid !== 1'b0 || reject !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: board/outcome/count/valid/reject got %h/%0d/%0d/%b/%b expected 0", board, outcome, move_count, valid, reject);
        end
        @(negedge clk);
        rst = 1'b1;
        // Button held through reset must not fire.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (valid !== 1'b0 || reject !== 1'b0 || board !== 18'd0) begin
                miscompares++;
                $display("FAIL reset_held: valid/reject/board got %b/%b/%h expected 0/0/0", valid, reject, board);
            end
        end
        @(negedge clk);
        check = 1'b0;
        @(posedge clk);
        model_clear();
    endtask

    task automatic test_first_and_taken();
        press(4'd5, 2'd1, "first_move");
        vectors++;
        if (board[9:8] !== 2'b01) begin
            miscompares++;
            $display("FAIL first_cell: board[9:8] got %b expected 01", board[9:8]);
        end
        press(4'd5, 2'd2, "cell_taken");
    endtask

    task automatic test_illegal();
        do_new_game();
        press(4'd0,  2'd1, "illegal_move0");
        press(4'd12, 2'd1, "illegal_move12");
        press(4'd1,  2'd3, "illegal_user3");
        press(4'd2,  2'd0, "illegal_user0");
    endtask

    task automatic test_row_win();
        do_new_game();
        press(4'd1, 2'd1, "row_p1a");
        press(4'd4, 2'd2, "row_p2a");
        press(4'd2, 2'd1, "row_p1b");
        press(4'd5, 2'd2, "row_p2b");
        press(4'd3, 2'd1, "row_p1c");
        press(4'd9, 2'd2, "row_over_ignored");
        press(4'd9, 2'd1, "row_over_ignored2");
    endtask

    task automatic test_diag_and_tie();
        do_new_game();
        press(4'd1, 2'd1, "diag_p1a");
        press(4'd3, 2'd2, "diag_p2a");
        press(4'd2, 2'd1, "diag_p1b");
        press(4'd5, 2'd2, "diag_p2b");
        press(4'd9, 2'd1, "diag_p1c");
        press(4'd7, 2'd2, "diag_p2c");
        do_new_game();
        press(4'd1, 2'd1, "tie1"); press(4'd2, 2'd2, "tie2");
        press(4'd3, 2'd1, "tie3"); press(4'd5, 2'd2, "tie4");
        press(4'd4, 2'd1, "tie5"); press(4'd6, 2'd2, "tie6");
        press(4'd8, 2'd1, "tie7"); press(4'd7, 2'd2, "tie8");
        press(4'd9, 2'd1, "tie9");
    endtask

    task automatic test_hold_and_clear();
        int pulses;
        do_new_game();
        pulses = 0;
        @(negedge clk);
        move = 4'd1; user = 2'd1; check = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (valid === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL hold_pulses: valid pulses got %0d expected 1", pulses);
        end
        // Clear while the button is still held.
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (board !== 18'd0 || outcome !== 3'd0 || move_count !== 4'd0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_clear: board/outcome/count/valid got %h/%0d/%0d/%b expected 0", board, outcome, move_count, valid);
        end
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (valid === 1'b1 || reject === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0 || board !== 18'd0) begin
            miscompares++;
            $display("FAIL hold_after_clear: pulses/board got %0d/%h expected 0/0", pulses, board);
        end
        @(negedge clk);
        check = 1'b0;
        @(posedge clk);
        press(4'd1, 2'd1, "repress");
    endtask

    task automatic test_collisions();
        // new_game and a rising check in the same cycle: clear wins.
        do_new_game();
        press(4'd2, 2'd2, "pre_collide");
        @(negedge clk);
        move = 4'd1; user = 2'd1; check = 1'b1; new_game = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (valid !== 1'b0 || reject !== 1'b0 || board !== 18'd0) begin
            miscompares++;
            $display("FAIL collide: valid/reject/board got %b/%b/%h expected 0/0/0", valid, reject, board);
        end
        @(negedge clk);
        new_game = 1'b0; check = 1'b0;
        @(posedge clk);
        model_clear();
        // Reset while the winning move is being evaluated.
        press(4'd1, 2'd1, "rst_eval_a");
        press(4'd2, 2'd1, "rst_eval_b");
        @(negedge clk);
        move = 4'd3; user = 2'd1; check = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (outcome !== 3'd0 || board !== 18'd0 || move_count !== 4'd0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_eval: outcome/board/count/valid got %0d/%h/%0d/%b expected 0", outcome, board, move_count, valid);
        end
        @(negedge clk);
        rst = 1'b1; check = 1'b0;
        @(posedge clk);
        model_clear();
    endtask

    task automatic test_random();
        logic [3:0] mv;
        logic [1:0] us;
        for (int n = 0; n < 250; n++) begin
            if (m_over && $urandom_range(0, 2) == 0) do_new_game();
            else if ($urandom_range(0, 40) == 0) do_new_game();
            mv = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 9));
            us = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
            press(mv, us, "random");
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_first_and_taken();
        test_illegal();
        test_row_win();
        test_diag_and_tie();
        test_hold_and_clear();
        test_collisions();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_move_judge
`default_nettype wire
